braid_mix_sequencer: RTL

- Time-multiplexed controller for an N_ROWS x N_STAGES mixer braid network (default 8 x 16).
- Per run: opens the inlet valves to load the braid, then enables mixer columns one at a time from the inlet side (column N_STAGES-1) toward the outlet side (column 0).
- After the last column, hands the mixed outputs to a downstream sampler through a valid/ready handshake, then flushes the network.
- Sits between the host run-control logic and the valve/pump driver bank of the braid.

---
 rtl/braid_mix_sequencer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/braid_mix_sequencer.sv
// braid_mix_sequencer: run controller for an N_ROWS x N_STAGES mixer braid.
// Loads the braid, walks the mixer columns from the inlet side to the outlet side,
// offers the product to a downstream sampler, then flushes the network.
module braid_mix_sequencer #(
  parameter int unsigned N_ROWS   = 8,
  parameter int unsigned N_STAGES = 16,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned SIDX_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                hold,
  input  logic [CNT_W-1:0]    cfg_fill,
  input  logic [CNT_W-1:0]    cfg_mix,
  input  logic [CNT_W-1:0]    cfg_flush,
  output logic [N_ROWS-1:0]   inlet_en,
  output logic [N_STAGES-1:0] mixer_col_en,
  output logic [SIDX_W-1:0]   stage_idx,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N_ROWS-1:0]   outlet_en,
  output logic                flush_en,
  output logic                busy,
  output logic                done,
  output logic                aborted
);

  localparam logic [SIDX_W-1:0] LAST_COL = SIDX_W'(N_STAGES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MIX,
    S_SAMPLE,
    S_FLUSH
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SIDX_W-1:0]     stage_q, stage_d;
  logic [CNT_W-1:0]      mix_len_q, mix_len_d;
  logic [CNT_W-1:0]      flush_len_q, flush_len_d;
  logic                  abort_run_q, abort_run_d;
  logic [N_ROWS-1:0]     inlet_en_q, inlet_en_d;
  logic [N_STAGES-1:0]   mixer_col_en_q, mixer_col_en_d;
  logic                  out_valid_q, out_valid_d;
  logic [N_ROWS-1:0]     outlet_en_q, outlet_en_d;
  logic                  flush_en_q, flush_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  aborted_q, aborted_d;

  // A programmed duration of zero still runs the phase for one cycle
  function automatic logic [CNT_W-1:0] nz(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  // Next-state, counter and registered-output decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stage_d     = stage_q;
    mix_len_d   = mix_len_q;
    flush_len_d = flush_len_q;
    abort_run_d = abort_run_q;
    aborted_d   = aborted_q;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d     = S_LOAD;
          cnt_d       = nz(cfg_fill) - CNT_W'(1);
          mix_len_d   = nz(cfg_mix);
          flush_len_d = nz(cfg_flush);
          abort_run_d = 1'b0;
          aborted_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d     = S_FLUSH;
          cnt_d       = flush_len_q - CNT_W'(1);
          abort_run_d = 1'b1;
        end else if (!hold) begin
          if (cnt_q == '0) begin
            state_d = S_MIX;
            stage_d = LAST_COL;
            cnt_d   = mix_len_q - CNT_W'(1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      S_MIX: begin
        if (abort) begin
          state_d     = S_FLUSH;
          stage_d     = '0;
          cnt_d       = flush_len_q - CNT_W'(1);
          abort_run_d = 1'b1;
        end else if (!hold) begin
          if (cnt_q == '0) begin
            if (stage_q == '0) begin
              state_d = S_SAMPLE;
            end else begin
              stage_d = stage_q - SIDX_W'(1);
              cnt_d   = mix_len_q - CNT_W'(1);
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      S_SAMPLE: begin
        if (abort) begin
          state_d     = S_FLUSH;
          cnt_d       = flush_len_q - CNT_W'(1);
          abort_run_d = 1'b1;
        end else if (out_ready) begin
          state_d = S_FLUSH;
          cnt_d   = flush_len_q - CNT_W'(1);
        end
      end
      S_FLUSH: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          if (abort_run_q) aborted_d = 1'b1;
          abort_run_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        stage_d = '0;
        cnt_d   = '0;
      end
    endcase

    // Outputs follow the state being entered so they change on the transition edge
    inlet_en_d     = (state_d == S_LOAD) ? '1 : '0;
    mixer_col_en_d = (state_d == S_MIX) ? (N_STAGES'(1) << stage_d) : '0;
    out_valid_d    = (state_d == S_SAMPLE);
    outlet_en_d    = (state_d == S_SAMPLE || state_d == S_FLUSH) ? '1 : '0;
    flush_en_d     = (state_d == S_FLUSH);
    busy_d         = (state_d != S_IDLE);
  end

  // State, counters and output registers; reset drops every valve and pump at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      stage_q        <= '0;
      mix_len_q      <= '0;
      flush_len_q    <= '0;
      abort_run_q    <= 1'b0;
      inlet_en_q     <= '0;
      mixer_col_en_q <= '0;
      out_valid_q    <= 1'b0;
      outlet_en_q    <= '0;
      flush_en_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      aborted_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stage_q        <= stage_d;
      mix_len_q      <= mix_len_d;
      flush_len_q    <= flush_len_d;
      abort_run_q    <= abort_run_d;
      inlet_en_q     <= inlet_en_d;
      mixer_col_en_q <= mixer_col_en_d;
      out_valid_q    <= out_valid_d;
      outlet_en_q    <= outlet_en_d;
      flush_en_q     <= flush_en_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      aborted_q      <= aborted_d;
    end
  end

  assign inlet_en     = inlet_en_q;
  assign mixer_col_en = mixer_col_en_q;
  assign stage_idx    = stage_q;
  assign out_valid    = out_valid_q;
  assign outlet_en    = outlet_en_q;
  assign flush_en     = flush_en_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign aborted      = aborted_q;

endmodule
